xp_port_rx: RTL and testbench
=============================

XP_PORT_RX -- requirements
Module: xp_port_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 Parameters (name, default, meaning):
- CHANNEL_TYPE, "REQ", expected channel: "REQ"=00, "RSP"=01, "DAT"=10, "SNP"=11.
- VC_DEPTH, 4, entries per VC buffer (power of two, at least 2).
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- in_valid, in, 1, upstream flit valid.
- in_ready, out, 1, flit accepted this cycle if in_valid.
- in_flit, in, flit_u, incoming flit.
- in_vc_id, in, 2, target VC of in_flit.
- in_channel_type, in, 2, channel code of in_flit.
- in_credit_count, out, CREDIT_COUNT_WIDTH, free entries of VC in_vc_id.
- in_credit_return, in, 1, upstream strobe; unused, any value tolerated.
- out_valid, out, 1, dequeued flit valid.
- out_ready, in, 1, router core accepts.
- out_flit, out, flit_u, head flit of granted VC.
- out_vc_id, out, 2, granted VC.
- crd_rtn_valid, out, 1, one-cycle credit return pulse.
- crd_rtn_vc, out, 2, VC of returned credit.
- err_chan_type, out, 1, sticky channel-type mismatch flag.

Function
REQ-004 The block SHALL hold four independent FIFOs, one per VC, each VC_DEPTH entries of flit_u.
REQ-005 in_ready SHALL be the combinational inverse of "FIFO[in_vc_id] full", using the count registered at the start of the cycle; there is no same-cycle dequeue bypass.
REQ-006 in_credit_count SHALL equal VC_DEPTH minus the occupancy of FIFO[in_vc_id], zero-extended to CREDIT_COUNT_WIDTH.
REQ-007 On in_valid and in_ready, in_flit SHALL be written at the VC's write pointer; it becomes visible at out_flit no earlier than the next cycle (minimum latency 1).
REQ-008 out_valid SHALL be 1 when any FIFO is non-empty; out_vc_id SHALL be chosen round-robin, starting the search at (last granted VC + 1) mod 4.
REQ-009 The round-robin pointer SHALL update only on out_valid and out_ready; while stalled, out_vc_id and out_flit SHALL be held stable.
REQ-010 On out_valid and out_ready, the granted FIFO SHALL pop. In the next cycle, crd_rtn_valid SHALL be 1 and crd_rtn_vc SHALL be the popped VC, so one credit is returned per pop.
REQ-011 Enqueue and dequeue on the same VC in the same cycle SHALL leave the occupancy unchanged and SHALL both complete. A full VC SHALL still reject the enqueue per REQ-005.
REQ-012 Pointers SHALL be log2(VC_DEPTH) bits and wrap modulo VC_DEPTH; occupancy SHALL be log2(VC_DEPTH)+1 bits.
REQ-013 An accepted flit with in_channel_type not equal to the CHANNEL_TYPE code SHALL still be enqueued, and SHALL set err_chan_type to 1 until reset.
REQ-014 in_valid while in_ready is 0 SHALL cause no state change.

Reset
REQ-015 While rst_n is 0:
- all FIFOs SHALL be empty and all pointers 0;
- the round-robin pointer SHALL be 3, so VC0 has first priority;
- out_valid, crd_rtn_valid and err_chan_type SHALL be 0, and crd_rtn_vc SHALL be 0;
- in_ready SHALL be 1 and in_credit_count SHALL be VC_DEPTH.
REQ-016 Reset asserted mid-operation SHALL discard all buffered flits and pending credit pulses immediately, with no credit returned for them.

Structure
REQ-017 flit_u, CREDIT_COUNT_WIDTH and the channel-type codes SHALL come from coh_noc_pkg.
REQ-018 The VC count (4) SHALL be a coh_noc_pkg constant.
REQ-019 Each VC buffer SHALL be an instance of a single sub-module, xp_vc_fifo (push, pop, full, empty, count, head), instantiated four times.

Verification
REQ-020 After reset, push 4 flits on VC2 with out_ready=0: in_credit_count for VC2 steps 4,3,2,1,0; in_ready=0 on the fifth attempt; the fifth flit is not stored.
REQ-021 With VC0, VC1 and VC3 each holding 2 flits and out_ready=1: out_vc_id sequence is 0,1,3,0,1,3; crd_rtn_valid pulses 6 times, each one cycle after its pop, with matching crd_rtn_vc.
REQ-022 With VC1 full and out_ready=1 granting VC1, drive in_valid on VC1 in the same cycle: in_ready=0, occupancy drops to 3, and the next-cycle push succeeds.
REQ-023 With CHANNEL_TYPE="DAT", push a flit with in_channel_type=00: the flit is dequeued intact and err_chan_type=1 stays set until rst_n is asserted.
REQ-024 Assert rst_n=0 asynchronously while VC0 holds 3 flits and a credit pulse is pending: out_valid=0 and crd_rtn_valid=0 immediately, and after release in_credit_count=4 on all VCs.
REQ-025 Hold out_ready=0 for 10 cycles with 1 flit in VC3: out_flit and out_vc_id=3 stay stable; no credit pulse occurs.

Source files
------------

// File: rtl/coh_noc_pkg.sv
// Shared types and constants for the coherent NoC crosspoint ports:
// flit layout, channel codes, VC count and credit-counter width.
package coh_noc_pkg;

    localparam int NUM_VC             = 4;
    localparam int VC_ID_WIDTH        = 2;
    localparam int CREDIT_COUNT_WIDTH = 4;
    localparam int FLIT_WIDTH         = 32;

    typedef enum logic [1:0] {
        CHAN_REQ = 2'b00,
        CHAN_RSP = 2'b01,
        CHAN_DAT = 2'b10,
        CHAN_SNP = 2'b11
    } chan_e;

    typedef struct packed {
        logic [7:0]  txn_id;
        logic [3:0]  opcode;
        logic [19:0] addr;
    } req_flit_t;

    typedef union packed {
        logic [FLIT_WIDTH-1:0] raw;
        req_flit_t             req;
    } flit_u;

    typedef enum logic {
        ARB_FREE,
        ARB_HOLD
    } arb_state_e;

    // Maps a three-letter channel name to its wire code; unknown names fall back to REQ.
    function automatic chan_e chan_code(input logic [23:0] name);
        case (name)
            "RSP":   return CHAN_RSP;
            "DAT":   return CHAN_DAT;
            "SNP":   return CHAN_SNP;
            default: return CHAN_REQ;
        endcase
    endfunction

endpackage

// File: rtl/xp_port_rx_if.sv
// Flit/credit bundle between an upstream sender, the receive port and the router core.
// master = upstream + core side, slave = the receive port.
interface xp_port_rx_if;
    import coh_noc_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    flit_u                         in_flit;
    logic [VC_ID_WIDTH-1:0]        in_vc_id;
    logic [1:0]                    in_channel_type;
    logic [CREDIT_COUNT_WIDTH-1:0] in_credit_count;
    logic                          in_credit_return;
    logic                          out_valid;
    logic                          out_ready;
    flit_u                         out_flit;
    logic [VC_ID_WIDTH-1:0]        out_vc_id;
    logic                          crd_rtn_valid;
    logic [VC_ID_WIDTH-1:0]        crd_rtn_vc;
    logic                          err_chan_type;

    modport master (
        output in_valid, in_flit, in_vc_id, in_channel_type, in_credit_return, out_ready,
        input  in_ready, in_credit_count, out_valid, out_flit, out_vc_id,
               crd_rtn_valid, crd_rtn_vc, err_chan_type
    );

    modport slave (
        input  in_valid, in_flit, in_vc_id, in_channel_type, in_credit_return, out_ready,
        output in_ready, in_credit_count, out_valid, out_flit, out_vc_id,
               crd_rtn_valid, crd_rtn_vc, err_chan_type
    );

endinterface

// File: rtl/xp_vc_fifo.sv
// Single virtual-channel flit buffer: power-of-two depth, wrapping pointers,
// explicit occupancy counter so full/empty need no extra pointer bit.
module xp_vc_fifo
    import coh_noc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  flit_u       din,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count,
    output flit_u       head
);

    flit_u         mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/xp_port_rx.sv
// Crosspoint receive port: four per-VC flit buffers, round-robin dequeue with
// grant locking while the core stalls, one credit pulse per pop.
module xp_port_rx
    import coh_noc_pkg::*;
#(
    parameter logic [23:0] CHANNEL_TYPE = "REQ",
    parameter int          VC_DEPTH     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    xp_port_rx_if.slave  port_if
);

    localparam int         PW        = $clog2(VC_DEPTH);
    localparam logic [1:0] CHAN_CODE = chan_code(CHANNEL_TYPE);

    logic [NUM_VC-1:0]      push_vec, pop_vec, full_vec, empty_vec;
    logic [PW:0]            count_arr [NUM_VC];
    flit_u                  head_arr  [NUM_VC];

    arb_state_e             state, next_state;
    logic [VC_ID_WIDTH-1:0] rr_ptr, next_rr;
    logic [VC_ID_WIDTH-1:0] held_vc, next_held;
    logic [VC_ID_WIDTH-1:0] search_vc, cand, grant_vc;
    logic                   accept, pop;
    logic                   unused_credit_return;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        xp_vc_fifo #(.DEPTH(VC_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_vec[v]),
            .pop   (pop_vec[v]),
            .din   (port_if.in_flit),
            .full  (full_vec[v]),
            .empty (empty_vec[v]),
            .count (count_arr[v]),
            .head  (head_arr[v])
        );
    end

    assign unused_credit_return = port_if.in_credit_return;

    assign port_if.in_ready        = ~full_vec[port_if.in_vc_id];
    assign port_if.in_credit_count = CREDIT_COUNT_WIDTH'(VC_DEPTH)
                                   - CREDIT_COUNT_WIDTH'(count_arr[port_if.in_vc_id]);
    assign accept = port_if.in_valid & port_if.in_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        if (accept) push_vec[port_if.in_vc_id] = 1'b1;
        if (pop)    pop_vec[grant_vc]          = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_FREE;
            rr_ptr  <= VC_ID_WIDTH'(NUM_VC - 1);
            held_vc <= '0;
        end else begin
            state   <= next_state;
            rr_ptr  <= next_rr;
            held_vc <= next_held;
        end
    end

    // A stalled grant is locked so a newly filled, higher-priority VC cannot steal it.
    always_comb begin
        next_state = state;
        next_rr    = rr_ptr;
        next_held  = held_vc;
        if (pop) begin
            next_state = ARB_FREE;
            next_rr    = grant_vc;
        end else if (port_if.out_valid) begin
            next_state = ARB_HOLD;
            next_held  = grant_vc;
        end
    end

    // Descending scan so the last hit is the nearest VC after rr_ptr.
    always_comb begin
        search_vc = rr_ptr;
        cand      = '0;
        for (int i = NUM_VC; i >= 1; i--) begin
            cand = rr_ptr + VC_ID_WIDTH'(i);
            if (!empty_vec[cand]) search_vc = cand;
        end
        grant_vc          = (state == ARB_HOLD) ? held_vc : search_vc;
        port_if.out_valid = ~&empty_vec;
        port_if.out_vc_id = grant_vc;
        port_if.out_flit  = head_arr[grant_vc];
        pop               = port_if.out_valid & port_if.out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_if.crd_rtn_valid <= 1'b0;
            port_if.crd_rtn_vc    <= '0;
        end else begin
            port_if.crd_rtn_valid <= pop;
            if (pop) port_if.crd_rtn_vc <= grant_vc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            port_if.err_chan_type <= 1'b0;
        else if (accept && port_if.in_channel_type != CHAN_CODE) port_if.err_chan_type <= 1'b1;
    end

endmodule

// File: tb/tb_xp_port_rx.sv
// Directed scenarios plus a randomized run against a queue-based model of the receive port.
module tb_xp_port_rx;
    import coh_noc_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    xp_port_rx_if bus ();

    xp_port_rx #(.CHANNEL_TYPE("DAT"), .VC_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .port_if (bus.slave)
    );

    task automatic idle_inputs();
        bus.in_valid         = 1'b0;
        bus.in_flit          = '0;
        bus.in_vc_id         = 2'd0;
        bus.in_channel_type  = 2'b10;
        bus.in_credit_return = 1'($urandom_range(0, 1));
        bus.out_ready        = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_one(input logic [1:0] vc, input flit_u f);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vc_id = vc;
        bus.in_flit  = f;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL reset_crd_valid: got %b want 0", bus.crd_rtn_valid); else n_pass++;
        n_total++; if (bus.crd_rtn_vc !== 2'd0) $display("FAIL reset_crd_vc: got %0d want 0", bus.crd_rtn_vc); else n_pass++;
        n_total++; if (bus.err_chan_type !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_chan_type); else n_pass++;
        for (int v = 0; v < NUM_VC; v++) begin
            bus.in_vc_id = 2'(v);
            #1;
            n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready vc%0d: got %b want 1", v, bus.in_ready); else n_pass++;
            n_total++; if (bus.in_credit_count !== 4'(DEPTH)) $display("FAIL reset_credit vc%0d: got %0d want %0d", v, bus.in_credit_count, DEPTH); else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_credit_fill();
        flit_u fl [5];
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            fl[k].raw = $urandom;
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_vc_id = 2'd2;
            bus.in_flit  = fl[k];
            #1;
            n_total++; if (bus.in_credit_count !== 4'(DEPTH - k)) $display("FAIL fill_credit step%0d: got %0d want %0d", k, bus.in_credit_count, DEPTH - k); else n_pass++;
            n_total++; if (bus.in_ready !== (k < DEPTH)) $display("FAIL fill_in_ready step%0d: got %b want %b", k, bus.in_ready, k < DEPTH); else n_pass++;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.out_vc_id !== 2'd2) $display("FAIL fill_out_vc: got %0d want 2", bus.out_vc_id); else n_pass++;
        for (int k = 0; k < DEPTH; k++) begin
            n_total++; if (bus.out_flit !== fl[k]) $display("FAIL fill_drain%0d: got %h want %h", k, bus.out_flit, fl[k]); else n_pass++;
            @(negedge clk);
            #1;
        end
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fill_fifth_not_stored: got out_valid %b want 0", bus.out_valid); else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        flit_u      ef [4][2];
        logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [1:0] vcs [3] = '{2'd0, 2'd1, 2'd3};
        apply_reset();
        foreach (vcs[i]) begin
            for (int j = 0; j < 2; j++) begin
                ef[vcs[i]][j].raw = $urandom;
                push_one(vcs[i], ef[vcs[i]][j]);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) begin
                n_total++; if (bus.out_vc_id !== seq[c]) $display("FAIL rr_vc%0d: got %0d want %0d", c, bus.out_vc_id, seq[c]); else n_pass++;
                n_total++; if (bus.out_flit !== ef[seq[c]][c / 3]) $display("FAIL rr_flit%0d: got %h want %h", c, bus.out_flit, ef[seq[c]][c / 3]); else n_pass++;
            end else begin
                n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rr_drained: got %b want 0", bus.out_valid); else n_pass++;
            end
            if (c > 0) begin
                n_total++; if (bus.crd_rtn_valid !== 1'b1) $display("FAIL rr_crd_valid%0d: got %b want 1", c, bus.crd_rtn_valid); else n_pass++;
                n_total++; if (bus.crd_rtn_vc !== seq[c-1]) $display("FAIL rr_crd_vc%0d: got %0d want %0d", c, bus.crd_rtn_vc, seq[c-1]); else n_pass++;
            end else begin
                n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL rr_crd_early: got %b want 0", bus.crd_rtn_valid); else n_pass++;
            end
            @(negedge clk);
            #1;
        end
        n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL rr_crd_extra: got %b want 0", bus.crd_rtn_valid); else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_pop_push();
        flit_u f [5];
        apply_reset();
        for (int k = 0; k < 5; k++) f[k].raw = $urandom;
        for (int k = 0; k < DEPTH; k++) push_one(2'd1, f[k]);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_vc_id  = 2'd1;
        bus.in_flit   = f[4];
        #1;
        n_total++; if (bus.out_vc_id !== 2'd1) $display("FAIL fpp_grant: got %0d want 1", bus.out_vc_id); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fpp_ready_full: got %b want 0", bus.in_ready); else n_pass++;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_total++; if (bus.in_credit_count !== 4'd1) $display("FAIL fpp_occ3: got credit %0d want 1", bus.in_credit_count); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fpp_retry_ready: got %b want 1", bus.in_ready); else n_pass++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_total++; if (bus.in_credit_count !== 4'd0) $display("FAIL fpp_refull: got credit %0d want 0", bus.in_credit_count); else n_pass++;
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            n_total++; if (bus.out_flit !== f[k]) $display("FAIL fpp_drain%0d: got %h want %h", k, bus.out_flit, f[k]); else n_pass++;
            @(negedge clk);
            #1;
        end
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL fpp_empty: got %b want 0", bus.out_valid); else n_pass++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_chan_err();
        flit_u a, b;
        a.raw = $urandom;
        b.raw = $urandom;
        apply_reset();
        push_one(2'd0, a);
        @(negedge clk);
        #1;
        n_total++; if (bus.err_chan_type !== 1'b0) $display("FAIL err_good_chan: got %b want 0", bus.err_chan_type); else n_pass++;
        bus.in_valid        = 1'b1;
        bus.in_vc_id        = 2'd0;
        bus.in_flit         = b;
        bus.in_channel_type = 2'b00;
        @(posedge clk);
        #1;
        bus.in_valid        = 1'b0;
        bus.in_channel_type = 2'b10;
        n_total++; if (bus.err_chan_type !== 1'b1) $display("FAIL err_set: got %b want 1", bus.err_chan_type); else n_pass++;
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.out_flit !== a) $display("FAIL err_first_flit: got %h want %h", bus.out_flit, a); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.out_flit !== b) $display("FAIL err_bad_flit_intact: got %h want %h", bus.out_flit, b); else n_pass++;
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_total++; if (bus.err_chan_type !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.err_chan_type); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.err_chan_type !== 1'b0) $display("FAIL err_cleared_by_reset: got %b want 0", bus.err_chan_type); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        flit_u f;
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            f.raw = $urandom;
            push_one(2'd0, f);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_total++; if (bus.crd_rtn_valid !== 1'b1) $display("FAIL mid_pending_pulse: got %b want 1", bus.crd_rtn_valid); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL mid_crd_valid: got %b want 0", bus.crd_rtn_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            bus.in_vc_id = 2'(v);
            #1;
            n_total++; if (bus.in_credit_count !== 4'(DEPTH)) $display("FAIL mid_credit vc%0d: got %0d want %0d", v, bus.in_credit_count, DEPTH); else n_pass++;
        end
        @(negedge clk);
        #1;
        n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL mid_no_late_pulse: got %b want 0", bus.crd_rtn_valid); else n_pass++;
    endtask

    task automatic test_stall();
        flit_u f, g;
        f.raw = $urandom;
        g.raw = $urandom;
        apply_reset();
        push_one(2'd3, f);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_vc_id = 2'd0;
        bus.in_flit  = g;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_total++; if (bus.out_vc_id !== 2'd3 || bus.out_valid !== 1'b1) $display("FAIL stall_vc%0d: got %0d/%b want 3/1", c, bus.out_vc_id, bus.out_valid); else n_pass++;
            n_total++; if (bus.out_flit !== f) $display("FAIL stall_flit%0d: got %h want %h", c, bus.out_flit, f); else n_pass++;
            n_total++; if (bus.crd_rtn_valid !== 1'b0) $display("FAIL stall_no_credit%0d: got %b want 0", c, bus.crd_rtn_valid); else n_pass++;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        n_total++; if (bus.out_vc_id !== 2'd0 || bus.out_flit !== g) $display("FAIL stall_next: got vc%0d %h want vc0 %h", bus.out_vc_id, bus.out_flit, g); else n_pass++;
        n_total++; if (bus.crd_rtn_valid !== 1'b1 || bus.crd_rtn_vc !== 2'd3) $display("FAIL stall_release_credit: got %b/%0d want 1/3", bus.crd_rtn_valid, bus.crd_rtn_vc); else n_pass++;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        flit_u      q [NUM_VC][$];
        int         last_vc = NUM_VC - 1;
        bit         held = 1'b0;
        int         held_vc = 0;
        bit         pend = 1'b0;
        int         pend_vc = 0;
        int         vc, gv, total, rdy_pct;
        bit         exp_ready;
        flit_u      fl;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rdy_pct = (cyc < 200) ? 30 : 75;
            vc      = $urandom_range(0, NUM_VC - 1);
            fl.raw  = $urandom;
            @(negedge clk);
            bus.in_valid         = ($urandom_range(0, 99) < 60);
            bus.in_vc_id         = 2'(vc);
            bus.in_flit          = fl;
            bus.in_credit_return = 1'($urandom_range(0, 1));
            bus.out_ready        = ($urandom_range(0, 99) < rdy_pct);
            #1;
            exp_ready = (q[vc].size() < DEPTH);
            total = 0;
            foreach (q[v]) total += q[v].size();
            gv = 0;
            if (held) gv = held_vc;
            else for (int i = NUM_VC; i >= 1; i--) if (q[(last_vc + i) % NUM_VC].size() > 0) gv = (last_vc + i) % NUM_VC;

            n_total++; if (bus.in_ready !== exp_ready) $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, bus.in_ready, exp_ready); else n_pass++;
            n_total++; if (bus.in_credit_count !== 4'(DEPTH - q[vc].size())) $display("FAIL rnd_credit c%0d: got %0d want %0d", cyc, bus.in_credit_count, DEPTH - q[vc].size()); else n_pass++;
            n_total++; if (bus.out_valid !== (total > 0)) $display("FAIL rnd_out_valid c%0d: got %b want %b", cyc, bus.out_valid, total > 0); else n_pass++;
            if (total > 0) begin
                n_total++; if (bus.out_vc_id !== 2'(gv)) $display("FAIL rnd_out_vc c%0d: got %0d want %0d", cyc, bus.out_vc_id, gv); else n_pass++;
                n_total++; if (bus.out_flit !== q[gv][0]) $display("FAIL rnd_out_flit c%0d: got %h want %h", cyc, bus.out_flit, q[gv][0]); else n_pass++;
            end
            n_total++; if (bus.crd_rtn_valid !== pend) $display("FAIL rnd_crd_valid c%0d: got %b want %b", cyc, bus.crd_rtn_valid, pend); else n_pass++;
            if (pend) begin
                n_total++; if (bus.crd_rtn_vc !== 2'(pend_vc)) $display("FAIL rnd_crd_vc c%0d: got %0d want %0d", cyc, bus.crd_rtn_vc, pend_vc); else n_pass++;
            end

            pend = 1'b0;
            if (total > 0 && bus.out_ready) begin
                void'(q[gv].pop_front());
                last_vc = gv;
                held    = 1'b0;
                pend    = 1'b1;
                pend_vc = gv;
            end else if (total > 0) begin
                held    = 1'b1;
                held_vc = gv;
            end
            if (bus.in_valid && exp_ready) q[vc].push_back(fl);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_credit_fill();
        test_round_robin();
        test_full_pop_push();
        test_chan_err();
        test_reset_mid();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
